// File: rtl/dmem_port_arbiter.sv
// Shares the single data_memory port between the MEM stage and an external burst engine.
// The core wins by default; ext gets a forced beat after MAX_WAIT consecutive losses.
module dmem_port_arbiter #(
  parameter int LEN_W    = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_mem_read,
  input  logic             core_mem_write,
  input  logic [31:0]      core_addr,
  input  logic [31:0]      core_wdata,
  output logic [31:0]      core_rdata,
  output logic             core_stall,
  input  logic             ext_start,
  input  logic             ext_we,
  input  logic [31:0]      ext_base_addr,
  input  logic [LEN_W-1:0] ext_len,
  input  logic [31:0]      ext_wdata,
  output logic             ext_wdata_pop,
  output logic [31:0]      ext_rdata,
  output logic             ext_rvalid,
  output logic             ext_busy,
  output logic             ext_done,
  output logic [31:0]      mem_access_addr,
  output logic [31:0]      mem_write_data,
  output logic             mem_write_en,
  output logic             mem_read_en,
  input  logic [31:0]      mem_read_data
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic             we_q, we_d;

  logic core_active;
  logic forced;
  logic ext_own;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      wait_q   <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      wait_q   <= wait_d;
      we_q     <= we_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    wait_d   = wait_q;
    we_d     = we_q;

    core_active = core_mem_read | core_mem_write;
    forced      = (state_q == BURST) && (wait_q == WAIT_MAX);
    ext_own     = (state_q == BURST) && (forced || !core_active);

    // Port defaults to the core; an ext beat overrides below.
    mem_access_addr = core_addr;
    mem_write_data  = core_wdata;
    mem_write_en    = core_mem_write;
    mem_read_en     = core_mem_read;
    core_rdata      = mem_read_data;
    ext_rdata       = mem_read_data;
    core_stall      = 1'b0;
    ext_wdata_pop   = 1'b0;
    ext_rvalid      = 1'b0;
    ext_busy        = (state_q == BURST);
    ext_done        = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (ext_start) begin
          we_d     = ext_we;
          addr_d   = ext_base_addr;
          remain_d = ext_len;
          wait_d   = '0;
          state_d  = (ext_len == '0) ? DONE : BURST;
        end
      end
      BURST: begin
        if (ext_own) begin
          mem_access_addr = addr_q;
          mem_write_data  = ext_wdata;
          mem_write_en    = we_q;
          mem_read_en     = !we_q;
          ext_wdata_pop   = we_q;
          ext_rvalid      = !we_q;
          core_stall      = core_active;
          addr_d          = addr_q + 32'd4;
          remain_d        = remain_q - 1'b1;
          wait_d          = '0;
          if (remain_q == LEN_W'(1)) state_d = DONE;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised bench for dmem_port_arbiter against a queue-based model of bursts and port ownership.
module tb_dmem_port_arbiter;
  localparam int LEN_W    = 8;
  localparam int MAX_WAIT = 4;

  logic             clk;
  logic             reset;
  logic             core_mem_read, core_mem_write;
  logic [31:0]      core_addr, core_wdata, core_rdata;
  logic             core_stall;
  logic             ext_start, ext_we;
  logic [31:0]      ext_base_addr;
  logic [LEN_W-1:0] ext_len;
  logic [31:0]      ext_wdata, ext_rdata;
  logic             ext_wdata_pop, ext_rvalid, ext_busy, ext_done;
  logic [31:0]      mem_access_addr, mem_write_data, mem_read_data;
  logic             mem_write_en, mem_read_en;

  dmem_port_arbiter #(.LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall(core_stall),
    .ext_start(ext_start), .ext_we(ext_we), .ext_base_addr(ext_base_addr),
    .ext_len(ext_len), .ext_wdata(ext_wdata), .ext_wdata_pop(ext_wdata_pop),
    .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid), .ext_busy(ext_busy),
    .ext_done(ext_done),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory seen by the DUT, written only from DUT outputs; golden is the model's view.
  logic [31:0] dut_mem [256];
  logic [31:0] golden  [256];
  assign mem_read_data = dut_mem[mem_access_addr[9:2]];

  int errors = 0;
  int checks = 0;

  // Model state: pending beat addresses of the accepted burst, losses since the last beat.
  logic [31:0] m_addrs[$];
  bit          m_active;
  bit          m_done_pending;
  bit          m_we;
  int          m_lost;

  bit          hold_req;
  int          held_op;
  logic [31:0] held_addr, held_wd;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  task automatic model_clear();
    m_addrs.delete();
    m_active       = 1'b0;
    m_done_pending = 1'b0;
    m_we           = 1'b0;
    m_lost         = 0;
    hold_req       = 1'b0;
  endtask

  // op: 0 = core idle, 1 = load, 2 = store.
  task automatic run_cycle(input bit start, input bit we, input logic [31:0] base,
                           input logic [LEN_W-1:0] len, input int op,
                           input logic [31:0] caddr, input logic [31:0] cwd);
    logic [31:0] e_addr, e_wd;
    logic        e_we, e_re, e_stall, e_pop, e_rv, e_busy, e_done, core_req, ext_wins;
    logic        w_en;
    logic [31:0] w_addr, w_data;
    @(negedge clk);
    reset = 1'b1;
    if (hold_req) begin
      op = held_op; caddr = held_addr; cwd = held_wd;
    end
    ext_start      = start;
    ext_we         = we;
    ext_base_addr  = base;
    ext_len        = len;
    ext_wdata      = $urandom();
    core_mem_read  = (op == 1);
    core_mem_write = (op == 2);
    core_addr      = caddr;
    core_wdata     = cwd;
    #1;
    core_req = (op != 0);
    ext_wins = m_active && (m_lost == MAX_WAIT || !core_req);
    e_busy   = m_active;
    e_done   = m_done_pending;
    e_addr = caddr; e_wd = cwd; e_we = (op == 2); e_re = (op == 1);
    e_stall = 1'b0; e_pop = 1'b0; e_rv = 1'b0;
    if (ext_wins) begin
      e_addr = m_addrs[0]; e_wd = ext_wdata; e_we = m_we; e_re = !m_we;
      e_pop = m_we; e_rv = !m_we; e_stall = core_req;
    end
    check_eq("ext_busy", ext_busy, e_busy);
    check_eq("ext_done", ext_done, e_done);
    check_eq("core_stall", core_stall, e_stall);
    check_eq("mem_write_en", mem_write_en, e_we);
    check_eq("mem_read_en", mem_read_en, e_re);
    check_eq("ext_wdata_pop", ext_wdata_pop, e_pop);
    check_eq("ext_rvalid", ext_rvalid, e_rv);
    if (e_we || e_re) check_eq("mem_access_addr", mem_access_addr, e_addr);
    if (e_we) check_eq("mem_write_data", mem_write_data, e_wd);
    if (e_rv) check_eq("ext_rdata", ext_rdata, golden[widx(e_addr)]);
    if (!ext_wins && op == 1) check_eq("core_rdata", core_rdata, golden[widx(caddr)]);

    // Advance the model by one clock.
    if (e_we) golden[widx(e_addr)] = e_wd;
    if (ext_wins) begin
      void'(m_addrs.pop_front());
      m_lost = 0;
      if (m_addrs.size() == 0) begin
        m_active = 1'b0;
        m_done_pending = 1'b1;
      end
    end else if (m_active) begin
      if (m_lost < MAX_WAIT) m_lost++;
    end else if (m_done_pending) begin
      m_done_pending = 1'b0;
    end else if (start) begin
      $display("burst start we=%0d base=%h len=%0d", we, base, len);
      m_we = we;
      m_lost = 0;
      for (int i = 0; i < int'(len); i++) m_addrs.push_back(base + 32'(4 * i));
      if (len == '0) m_done_pending = 1'b1;
      else m_active = 1'b1;
    end
    hold_req  = e_stall;
    held_op   = op;
    held_addr = caddr;
    held_wd   = cwd;

    w_en = mem_write_en; w_addr = mem_access_addr; w_data = mem_write_data;
    @(posedge clk);
    if (w_en) dut_mem[widx(w_addr)] = w_data;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 32'h0, '0, 0, 32'h0, 32'h0);
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    reset          = 1'b0;
    ext_start      = 1'b0;
    core_mem_read  = 1'b0;
    core_mem_write = 1'b0;
    #1;
    check_eq("rst_ext_busy", ext_busy, 1'b0);
    check_eq("rst_ext_done", ext_done, 1'b0);
    check_eq("rst_ext_rvalid", ext_rvalid, 1'b0);
    check_eq("rst_ext_wdata_pop", ext_wdata_pop, 1'b0);
    check_eq("rst_core_stall", core_stall, 1'b0);
    check_eq("rst_mem_write_en", mem_write_en, 1'b0);
    check_eq("rst_mem_read_en", mem_read_en, 1'b0);
    model_clear();
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b0;
    core_mem_read = 1'b0; core_mem_write = 1'b0; core_addr = '0; core_wdata = '0;
    ext_start = 1'b0; ext_we = 1'b0; ext_base_addr = '0; ext_len = '0; ext_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      dut_mem[i] = 32'h0;
      golden[i]  = 32'h0;
    end
    model_clear();
    reset_cycle();
    reset_cycle();

    // Write burst of 4 at 0x40 with the core idle.
    run_cycle(1'b1, 1'b1, 32'h40, 8'd4, 0, 32'h0, 32'h0);
    idle_cycles(6);
    // Read it back while the core loads every cycle: forced beats every 5th cycle.
    run_cycle(1'b1, 1'b0, 32'h40, 8'd3, 1, 32'h200, 32'h0);
    for (int i = 0; i < 18; i++) run_cycle(1'b0, 1'b0, 32'h0, '0, 1, 32'h200, 32'h0);
    // Core stores to 0x100 during a write burst.
    run_cycle(1'b1, 1'b1, 32'h80, 8'd3, 2, 32'h100, $urandom());
    for (int i = 0; i < 18; i++) run_cycle(1'b0, 1'b0, 32'h0, '0, 2, 32'h100, $urandom());
    idle_cycles(2);
    // Zero-length burst.
    run_cycle(1'b1, 1'b1, 32'h10, 8'd0, 0, 32'h0, 32'h0);
    idle_cycles(3);
    // ext_start while busy is ignored.
    run_cycle(1'b1, 1'b1, 32'h300, 8'd5, 0, 32'h0, 32'h0);
    run_cycle(1'b0, 1'b0, 32'h0, '0, 0, 32'h0, 32'h0);
    run_cycle(1'b1, 1'b0, 32'h3C0, 8'd9, 0, 32'h0, 32'h0);
    idle_cycles(6);
    // Address wrap.
    run_cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 8'd2, 0, 32'h0, 32'h0);
    idle_cycles(4);
    // Reset during the second beat of a 4-beat burst, then a fresh burst.
    run_cycle(1'b1, 1'b1, 32'h20, 8'd4, 0, 32'h0, 32'h0);
    run_cycle(1'b0, 1'b0, 32'h0, '0, 0, 32'h0, 32'h0);
    reset_cycle();
    idle_cycles(2);
    run_cycle(1'b1, 1'b1, 32'h60, 8'd2, 0, 32'h0, 32'h0);
    idle_cycles(4);

    // Random phase with varying core load.
    for (int seg = 0; seg < 4; seg++) begin
      int pct;
      pct = (seg == 0) ? 0 : (seg == 1) ? 50 : (seg == 2) ? 90 : 100;
      for (int c = 0; c < 400; c++) begin
        bit          st, wr;
        logic [31:0] base, caddr;
        int          op;
        st    = ($urandom_range(0, 5) == 0);
        wr    = 1'($urandom_range(0, 1));
        base  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 255)) << 2);
        caddr = 32'($urandom_range(0, 255)) << 2;
        op    = (int'($urandom_range(0, 99)) < pct) ? int'($urandom_range(1, 2)) : 0;
        run_cycle(st, wr, base, LEN_W'($urandom_range(0, 6)), op, caddr, $urandom());
      end
    end
    idle_cycles(40);

    for (int i = 0; i < 256; i++) check_eq("mem_contents", dut_mem[i], golden[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
